// File: rtl/intr_ctrl_pkg.sv
// Shared types and register-map constants for the OTTER interrupt controller.
package intr_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } intrState_t;

  localparam logic [3:0] OFS_MASK  = 4'h0;
  localparam logic [3:0] OFS_PEND  = 4'h4;
  localparam logic [3:0] OFS_CAUSE = 4'h8;
  localparam logic [3:0] OFS_ACK   = 4'hC;

  localparam int CAUSE_VALID_BIT = 31;

endpackage

// File: rtl/intr_edge_sync.sv
// One interrupt source: optional synchronizer chain, previous-value flop and
// rising-edge event. Deliberately unreset so a line held high across reset is not an event.
module intr_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic CLK,
  input  logic srcRaw,
  output logic srcEvt
);

  logic syncOut;
  logic prevReg;

  generate
    if (SYNC_STAGES == 0) begin : g_noSync
      assign syncOut = srcRaw;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] syncReg;

      always_ff @(posedge CLK) begin
        syncReg[0] <= srcRaw;
        for (int i = 1; i < SYNC_STAGES; i++) begin
          syncReg[i] <= syncReg[i-1];
        end
      end

      assign syncOut = syncReg[SYNC_STAGES-1];
    end
  endgenerate

  always_ff @(posedge CLK) begin
    prevReg <= syncOut;
  end

  assign srcEvt = syncOut & ~prevReg;

endmodule

// File: rtl/intr_ctrl.sv
// Interrupt controller: latches source edges into PEND, masks, picks the
// lowest-index active source as CAUSE and sequences INTR with an ACK holdoff.
module intr_ctrl
  import intr_ctrl_pkg::*;
#(
  parameter int          N_SRC       = 4,
  parameter logic [31:0] BASE_ADDR   = 32'h1100_0100,
  parameter int          HOLDOFF_CYC = 4,
  parameter int          SYNC_STAGES = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [N_SRC-1:0] SRC,
  input  logic [31:0]      IOBUS_ADDR,
  input  logic [31:0]      IOBUS_OUT,
  input  logic             IOBUS_WR,
  output logic [31:0]      RD_DATA,
  output logic             RD_HIT,
  output logic             INTR
);

  logic [N_SRC-1:0] srcEvt;
  logic [N_SRC-1:0] maskReg;
  logic [N_SRC-1:0] pendReg;
  logic [N_SRC-1:0] active;
  logic [N_SRC-1:0] ackVec;
  logic [3:0]       regOfs;
  logic             wrEn;
  logic             ackValid;
  logic             causeValid;
  logic [3:0]       causeIdx;

  intrState_t stateReg, stateNext;
  logic [7:0] cntReg, cntNext;

  genvar gi;
  generate
    for (gi = 0; gi < N_SRC; gi++) begin : g_src
      intr_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) uEdgeSync (
        .CLK    (CLK),
        .srcRaw (SRC[gi]),
        .srcEvt (srcEvt[gi])
      );
      assign ackVec[gi] = ackValid && (IOBUS_OUT[3:0] == 4'(gi));
    end
  endgenerate

  // Only the four word-aligned offsets inside our 16-byte window decode.
  assign RD_HIT   = (IOBUS_ADDR[31:4] == BASE_ADDR[31:4]) && (IOBUS_ADDR[1:0] == 2'b00);
  assign regOfs   = IOBUS_ADDR[3:0];
  assign wrEn     = IOBUS_WR && RD_HIT;
  assign ackValid = wrEn && (regOfs == OFS_ACK) && (IOBUS_OUT < 32'(N_SRC));

  always_ff @(posedge CLK) begin
    if (RST) begin
      maskReg <= '0;
      pendReg <= '0;
    end else begin
      if (wrEn && (regOfs == OFS_MASK)) begin
        maskReg <= IOBUS_OUT[N_SRC-1:0];
      end
      // A fresh event outranks an ACK of the same source so it is never lost.
      pendReg <= srcEvt | (pendReg & ~ackVec);
    end
  end

  assign active     = pendReg & maskReg;
  assign causeValid = |active;

  always_comb begin
    causeIdx = 4'd0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (active[i]) begin
        causeIdx = 4'(i);
      end
    end
  end

  always_comb begin
    RD_DATA = '0;
    if (RD_HIT) begin
      case (regOfs)
        OFS_MASK: RD_DATA[N_SRC-1:0] = maskReg;
        OFS_PEND: RD_DATA[N_SRC-1:0] = pendReg;
        OFS_CAUSE: begin
          if (causeValid) begin
            RD_DATA[CAUSE_VALID_BIT] = 1'b1;
            RD_DATA[3:0]             = causeIdx;
          end
        end
        default: RD_DATA = '0;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      stateReg <= IDLE;
      cntReg   <= 8'd0;
    end else begin
      stateReg <= stateNext;
      cntReg   <= cntNext;
    end
  end

  always_comb begin
    stateNext = stateReg;
    cntNext   = cntReg;
    case (stateReg)
      IDLE: begin
        if (causeValid) stateNext = REQ;
      end
      REQ: begin
        if (ackValid || !causeValid) begin
          stateNext = HOLD;
          cntNext   = 8'(HOLDOFF_CYC - 1);
        end
      end
      HOLD: begin
        if (cntReg == 8'd0) stateNext = IDLE;
        else                cntNext   = cntReg - 8'd1;
      end
      default: stateNext = IDLE;
    endcase
  end

  assign INTR = (stateReg == REQ);

endmodule

// File: doc/intr_ctrl.md
Name: intr_ctrl

Overview:
- Interrupt controller in front of the OTTER MCU's single INTR input.
- Collects N_SRC peripheral event lines for the snake game (game-tick timer, keypad, etc.). Edge-detects and latches them, applies a software mask and fixed priority, and sequences the INTR level into the core.
- Firmware drives it over IOBUS: reads the pending and cause registers, writes the mask, and acknowledges individual sources.

Parameters:
- N_SRC, 4: number of interrupt sources, 1..16.
- BASE_ADDR, 32'h1100_0100: IOBUS byte address of register 0. Word-aligned.
- HOLDOFF_CYC, 4: minimum INTR-low cycles after an acknowledge, 1..255.
- SYNC_STAGES, 2: synchronizer flops per source, 0..3. 0 means the sources are already in the CLK domain.

Ports:
- CLK  in  1  system clock.
- RST  in  1  synchronous, active-high reset.
- SRC  in  N_SRC  raw event lines; a rising edge is an event.
- IOBUS_ADDR  in  32  MCU IO address.
- IOBUS_OUT  in  32  MCU write data.
- IOBUS_WR  in  1  MCU write strobe; valid for one cycle.
- RD_DATA  out  32  read data for the top-level IOBUS_IN mux.
- RD_HIT  out  1  IOBUS_ADDR decodes to one of this block's registers.
- INTR  out  1  interrupt request to otter_mcu.INTR.

Behaviour:
- Register map (offset from BASE_ADDR):
  - 0x0 MASK, R/W, low N_SRC bits.
  - 0x4 PEND, RO.
  - 0x8 CAUSE, RO: bit31 = valid, bits[3:0] = source index.
  - 0xC ACK, WO: writing value k clears PEND[k].
  - Other offsets, and address bits not matching BASE_ADDR[31:4], give no hit.
  - Unused register bits read 0.
- Reads:
  - RD_DATA and RD_HIT are combinational from IOBUS_ADDR and the current registers, with zero latency.
  - RD_DATA is 0 when RD_HIT=0. A read of ACK returns 0.
- Writes: take effect on the CLK edge where IOBUS_WR=1 and the address hits. A write to PEND or CAUSE is ignored.
- ACK values ≥ N_SRC are ignored.
- Input path, per source:
  - SYNC_STAGES flops, then a prev flop.
  - event = sync & ~prev.
  - The synchronizer and prev flops are not reset; they keep tracking during RST. A source held high across reset therefore produces no event.
- PEND[i] next state:
  - cleared while RST=1;
  - else set if event[i];
  - else cleared on an ACK write of i;
  - else held.
  - Set wins over ACK in the same cycle, so a new event is never lost.
  - A repeat event while already pending merges into the single bit.
- active = PEND & MASK.
  - A MASK write never alters PEND.
  - Masked events still latch in PEND.
- CAUSE:
  - valid = |active.
  - idx = lowest set bit of active; index 0 has highest priority.
  - When valid=0, CAUSE reads 0.
- FSM (state register reset to IDLE):
  - IDLE: INTR=0. Go to REQ when |active=1.
  - REQ: INTR=1. Stays in REQ while |active=1. Go to HOLD on any valid ACK write, or when active becomes 0 (e.g. MASK cleared).
  - HOLD: INTR=0. On entry, load cnt=HOLDOFF_CYC-1 and decrement each cycle. At cnt=0 go to IDLE.
  - Pending sources re-raise INTR via IDLE→REQ. The minimum INTR low time is HOLDOFF_CYC+1 cycles after ACK.
- Output timing:
  - INTR is a registered output, decoded from the state register with no combinational input path.
  - An event at edge t (sync output) sets PEND at edge t+1, enters REQ at edge t+2, and raises INTR from edge t+2. With SYNC_STAGES=2 this is t+4 from the raw edge.
- Reset: synchronous; applies in any state. Mid-REQ reset drops INTR the cycle after the reset edge.
  - Reset values: MASK=0, PEND=0, state IDLE, cnt=0, INTR=0.
  - RD_DATA and RD_HIT follow the address; with registers cleared, RD_DATA reads 0.

Decomposition:
- Package intr_ctrl_pkg holds:
  - the state enum {IDLE, REQ, HOLD};
  - register offset constants OFS_MASK/OFS_PEND/OFS_CAUSE/OFS_ACK;
  - the CAUSE valid-bit position.
- Sub-module intr_edge_sync: one source's synchronizer chain, prev flop and event output, parameterized by SYNC_STAGES and instantiated N_SRC times via generate.
- Address decode, PEND/MASK registers, priority encoder and FSM live in intr_ctrl.

Test Plan:
- Reset hold: SRC=4'b0101 held high through RST, then RST released for 20 cycles → PEND=0, INTR=0. Reading BASE+0x4 gives RD_HIT=1, RD_DATA=0.
- Basic flow: write MASK=0xF; pulse SRC[2]; with SYNC_STAGES=2 → INTR=1 exactly 4 edges after the raw edge; CAUSE reads 0x8000_0002. Write ACK=2 → INTR low next cycle, PEND=0, INTR stays 0.
- Priority and holdoff: MASK=0xF, pulse SRC[3] and SRC[1] together → CAUSE idx=1. ACK=1 → INTR low for HOLDOFF_CYC+1=5 cycles, then high with CAUSE idx=3.
- Masking: MASK=0, pulse SRC[0] → PEND=0x1, INTR=0. Write MASK=0x1 → INTR rises 1 cycle later (IDLE→REQ). Writing MASK=0 while in REQ → HOLD, INTR drops.
- Set-vs-ACK race: align a SRC[1] event with an ACK=1 write on the same edge → PEND[1] stays 1 and INTR re-asserts after the holdoff. ACK=7 with N_SRC=4 → no change.
- Reset mid-operation: assert RST for one cycle while in REQ with PEND=0x6 → next cycle INTR=0, PEND=0, MASK=0, and the FSM idles.
